mmio_host_requester: RTL and testbench

- Synthesizable host-side MMIO initiator for the CCI-P MMIO path. It drives MMIO write and read requests into an AFU's MMIO responder and collects the read responses that come back on the c2 channel.
- It accepts commands over a valid/ready interface, assigns a transaction ID (tid) to each read, and tracks outstanding reads in a tag table.
- Each read completes with its data, a timeout error, or an unexpected-tid error.
- Used in loopback self-test tops and benches to exercise multi-cycle-latency MMIO responders.

---
 rtl/mmio_host_requester.sv | 227 ++++++++++++++++++++++
 tb/tb_mmio_host_requester.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_host_requester.sv
// Host-side CCI-P MMIO initiator: issues MMIO writes/reads, tracks outstanding
// reads in a tag table and reports each read as ok, timeout or unexpected tid.
module mmio_host_requester #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 64,
  parameter int TID_WIDTH       = 9
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic                                 cmd_wr,
  input  logic [ADDR_WIDTH-1:0]                cmd_addr,
  input  logic [DATA_WIDTH-1:0]                cmd_data,
  output logic                                 mmio_wr_valid,
  output logic                                 mmio_rd_valid,
  output logic [ADDR_WIDTH-1:0]                mmio_addr,
  output logic [TID_WIDTH-1:0]                 mmio_tid,
  output logic [DATA_WIDTH-1:0]                mmio_data,
  input  logic                                 rsp_valid,
  input  logic [TID_WIDTH-1:0]                 rsp_tid,
  input  logic [DATA_WIDTH-1:0]                rsp_data,
  output logic                                 done_valid,
  output logic [ADDR_WIDTH-1:0]                done_addr,
  output logic [DATA_WIDTH-1:0]                done_data,
  output logic [1:0]                           done_err,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int AW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [AW-1:0] AGE_MAX = AW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_TID     = 2'd2,
    ERR_ALIGN   = 2'd3
  } err_e;

  logic [MAX_OUTSTANDING-1:0] ent_valid_q, ent_valid_d;
  logic [TID_WIDTH-1:0]       ent_tid_q  [MAX_OUTSTANDING];
  logic [TID_WIDTH-1:0]       ent_tid_d  [MAX_OUTSTANDING];
  logic [ADDR_WIDTH-1:0]      ent_addr_q [MAX_OUTSTANDING];
  logic [ADDR_WIDTH-1:0]      ent_addr_d [MAX_OUTSTANDING];
  logic [AW-1:0]              ent_age_q  [MAX_OUTSTANDING];
  logic [AW-1:0]              ent_age_d  [MAX_OUTSTANDING];

  logic [TID_WIDTH-1:0]  tid_cnt_q, tid_cnt_d;
  logic [OW-1:0]         out_q, out_d;
  logic                  mis_pend_q, mis_pend_d;
  logic [ADDR_WIDTH-1:0] mis_addr_q, mis_addr_d;

  logic                  wr_valid_q, wr_valid_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [TID_WIDTH-1:0]  mtid_q, mtid_d;
  logic [DATA_WIDTH-1:0] mdata_q, mdata_d;

  logic                  done_valid_q, done_valid_d;
  logic [ADDR_WIDTH-1:0] done_addr_q, done_addr_d;
  logic [DATA_WIDTH-1:0] done_data_q, done_data_d;
  err_e                  done_err_q, done_err_d;

  logic          accept, is_mis, issue_wr, issue_rd, freed;
  logic          match_hit, to_hit, free_hit;
  logic [IW-1:0] match_idx, to_idx, free_idx;

  // A held misaligned completion blocks new commands so it can never be overwritten.
  assign cmd_ready = rst && (out_q < OW'(MAX_OUTSTANDING)) && !mis_pend_q;

  always_comb begin
    accept   = cmd_valid && cmd_ready;
    is_mis   = accept && cmd_addr[0];
    issue_wr = accept && !cmd_addr[0] && cmd_wr;
    issue_rd = accept && !cmd_addr[0] && !cmd_wr;

    match_hit = 1'b0;
    match_idx = '0;
    to_hit    = 1'b0;
    to_idx    = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (!match_hit && ent_valid_q[i] && ent_tid_q[i] == rsp_tid) begin
        match_hit = 1'b1;
        match_idx = IW'(i);
      end
      if (!to_hit && ent_valid_q[i] && ent_age_q[i] == AGE_MAX) begin
        to_hit = 1'b1;
        to_idx = IW'(i);
      end
      if (!free_hit && !ent_valid_q[i]) begin
        free_hit = 1'b1;
        free_idx = IW'(i);
      end
    end

    ent_valid_d = ent_valid_q;
    ent_tid_d   = ent_tid_q;
    ent_addr_d  = ent_addr_q;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      ent_age_d[i] = (ent_valid_q[i] && ent_age_q[i] != AGE_MAX) ? ent_age_q[i] + 1'b1
                                                                 : ent_age_q[i];
    end

    tid_cnt_d  = tid_cnt_q;
    mis_pend_d = mis_pend_q;
    mis_addr_d = mis_addr_q;
    wr_valid_d = issue_wr;
    rd_valid_d = issue_rd;
    maddr_d    = maddr_q;
    mtid_d     = mtid_q;
    mdata_d    = mdata_q;
    freed      = 1'b0;

    done_valid_d = 1'b0;
    done_addr_d  = '0;
    done_data_d  = '0;
    done_err_d   = ERR_OK;

    // Completion priority: response, new misaligned, held misaligned, timeout.
    if (rsp_valid) begin
      done_valid_d = 1'b1;
      done_data_d  = rsp_data;
      if (match_hit) begin
        done_addr_d            = ent_addr_q[match_idx];
        ent_valid_d[match_idx] = 1'b0;
        freed                  = 1'b1;
      end else begin
        done_err_d = ERR_TID;
      end
      if (is_mis) begin
        mis_pend_d = 1'b1;
        mis_addr_d = cmd_addr;
      end
    end else if (is_mis) begin
      done_valid_d = 1'b1;
      done_addr_d  = cmd_addr;
      done_err_d   = ERR_ALIGN;
    end else if (mis_pend_q) begin
      done_valid_d = 1'b1;
      done_addr_d  = mis_addr_q;
      done_err_d   = ERR_ALIGN;
      mis_pend_d   = 1'b0;
    end else if (to_hit) begin
      done_valid_d        = 1'b1;
      done_addr_d         = ent_addr_q[to_idx];
      done_err_d          = ERR_TIMEOUT;
      ent_valid_d[to_idx] = 1'b0;
      freed               = 1'b1;
    end

    if (issue_wr || issue_rd) begin
      maddr_d   = cmd_addr;
      mtid_d    = tid_cnt_q;
      mdata_d   = issue_wr ? cmd_data : '0;
      tid_cnt_d = tid_cnt_q + 1'b1;
    end
    // The allocated slot was free this cycle, so it never collides with the freed one.
    if (issue_rd && free_hit) begin
      ent_valid_d[free_idx] = 1'b1;
      ent_tid_d[free_idx]   = tid_cnt_q;
      ent_addr_d[free_idx]  = cmd_addr;
      ent_age_d[free_idx]   = '0;
    end

    out_d = out_q + OW'(issue_rd && free_hit) - OW'(freed);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_valid_q <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        ent_tid_q[i]  <= '0;
        ent_addr_q[i] <= '0;
        ent_age_q[i]  <= '0;
      end
      tid_cnt_q    <= '0;
      out_q        <= '0;
      mis_pend_q   <= 1'b0;
      mis_addr_q   <= '0;
      wr_valid_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      maddr_q      <= '0;
      mtid_q       <= '0;
      mdata_q      <= '0;
      done_valid_q <= 1'b0;
      done_addr_q  <= '0;
      done_data_q  <= '0;
      done_err_q   <= ERR_OK;
    end else begin
      ent_valid_q  <= ent_valid_d;
      ent_tid_q    <= ent_tid_d;
      ent_addr_q   <= ent_addr_d;
      ent_age_q    <= ent_age_d;
      tid_cnt_q    <= tid_cnt_d;
      out_q        <= out_d;
      mis_pend_q   <= mis_pend_d;
      mis_addr_q   <= mis_addr_d;
      wr_valid_q   <= wr_valid_d;
      rd_valid_q   <= rd_valid_d;
      maddr_q      <= maddr_d;
      mtid_q       <= mtid_d;
      mdata_q      <= mdata_d;
      done_valid_q <= done_valid_d;
      done_addr_q  <= done_addr_d;
      done_data_q  <= done_data_d;
      done_err_q   <= done_err_d;
    end
  end

  assign mmio_wr_valid = wr_valid_q;
  assign mmio_rd_valid = rd_valid_q;
  assign mmio_addr     = maddr_q;
  assign mmio_tid      = mtid_q;
  assign mmio_data     = mdata_q;
  assign done_valid    = done_valid_q;
  assign done_addr     = done_addr_q;
  assign done_data     = done_data_q;
  assign done_err      = done_err_q;
  assign outstanding   = out_q;

endmodule

// File: tb/tb_mmio_host_requester.sv
// Directed bench for mmio_host_requester: expected MMIO requests and completions
// are queued as stimulus is driven and compared by a monitor when the DUT emits them.
module tb_mmio_host_requester;

  localparam int MAXO = 4;
  localparam int TO   = 64;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [8:0]  tid;
    logic [63:0] data;
  } req_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [63:0] data;
    logic [1:0]  err;
  } done_t;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [15:0] cmd_addr;
  logic [63:0] cmd_data;
  logic        mmio_wr_valid;
  logic        mmio_rd_valid;
  logic [15:0] mmio_addr;
  logic [8:0]  mmio_tid;
  logic [63:0] mmio_data;
  logic        rsp_valid;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data;
  logic        done_valid;
  logic [15:0] done_addr;
  logic [63:0] done_data;
  logic [1:0]  done_err;
  logic [2:0]  outstanding;

  int    vectors     = 0;
  int    miscompares = 0;
  logic [8:0] exp_tid = '0;
  req_t  exp_req_q[$];
  done_t exp_done_q[$];

  mmio_host_requester #(
    .MAX_OUTSTANDING(MAXO),
    .TIMEOUT_CYCLES (TO),
    .ADDR_WIDTH     (16),
    .DATA_WIDTH     (64),
    .TID_WIDTH      (9)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_wr       (cmd_wr),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .mmio_wr_valid(mmio_wr_valid),
    .mmio_rd_valid(mmio_rd_valid),
    .mmio_addr    (mmio_addr),
    .mmio_tid     (mmio_tid),
    .mmio_data    (mmio_data),
    .rsp_valid    (rsp_valid),
    .rsp_tid      (rsp_tid),
    .rsp_data     (rsp_data),
    .done_valid   (done_valid),
    .done_addr    (done_addr),
    .done_data    (done_data),
    .done_err     (done_err),
    .outstanding  (outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one command for one clock; queues the request or misaligned completion it implies.
  task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [63:0] data,
                               output logic [8:0] tid_o);
    req_t  r;
    done_t d;
    tid_o = exp_tid;
    if (addr[0]) begin
      d.addr = addr;
      d.data = '0;
      d.err  = 2'd3;
      exp_done_q.push_back(d);
    end else begin
      r.wr   = wr;
      r.addr = addr;
      r.tid  = exp_tid;
      r.data = data;
      exp_req_q.push_back(r);
      exp_tid = exp_tid + 9'd1;
    end
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_data  = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic sendResponse(input logic [8:0] tid, input logic [63:0] data,
                              input logic [15:0] exp_addr, input logic [1:0] exp_err);
    done_t d;
    d.addr = exp_addr;
    d.data = data;
    d.err  = exp_err;
    exp_done_q.push_back(d);
    rsp_valid = 1'b1;
    rsp_tid   = tid;
    rsp_data  = data;
    @(posedge clk);
    #1;
    rsp_valid = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin : monitor
    req_t  r;
    done_t d;
    if (mmio_wr_valid || mmio_rd_valid) begin
      checkOutput("req_expected", 64'(exp_req_q.size() != 0), 64'd1);
      if (exp_req_q.size() != 0) begin
        r = exp_req_q.pop_front();
        checkOutput("req_wr", 64'(mmio_wr_valid), 64'(r.wr));
        checkOutput("req_rd", 64'(mmio_rd_valid), 64'(!r.wr));
        checkOutput("req_addr", 64'(mmio_addr), 64'(r.addr));
        checkOutput("req_tid", 64'(mmio_tid), 64'(r.tid));
        if (r.wr) checkOutput("req_data", mmio_data, r.data);
      end
    end
    if (done_valid) begin
      checkOutput("done_expected", 64'(exp_done_q.size() != 0), 64'd1);
      if (exp_done_q.size() != 0) begin
        d = exp_done_q.pop_front();
        checkOutput("done_addr", 64'(done_addr), 64'(d.addr));
        checkOutput("done_data", done_data, d.data);
        checkOutput("done_err", 64'(done_err), 64'(d.err));
      end
    end
  end

  initial begin
    logic [8:0] t;
    logic [8:0] tids[4];
    logic [8:0] rt0, rt1;

    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = '0;
    cmd_data  = '0;
    rsp_valid = 1'b0;
    rsp_tid   = '0;
    rsp_data  = '0;

    // Reset state
    @(negedge clk);
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    checkOutput("rst_wr_valid", 64'(mmio_wr_valid), 64'd0);
    checkOutput("rst_rd_valid", 64'(mmio_rd_valid), 64'd0);
    checkOutput("rst_mmio_addr", 64'(mmio_addr), 64'd0);
    checkOutput("rst_mmio_data", mmio_data, 64'd0);
    checkOutput("rst_done_valid", 64'(done_valid), 64'd0);
    checkOutput("rst_done_err", 64'(done_err), 64'd0);
    checkOutput("rst_outstanding", 64'(outstanding), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_rst", 64'(cmd_ready), 64'd1);

    // Write
    applyStimulus(1'b1, 16'h0020, 64'hDEAD_BEEF, t);
    @(negedge clk);
    checkOutput("wr_strobe", 64'(mmio_wr_valid), 64'd1);
    checkOutput("wr_no_done", 64'(done_valid), 64'd0);
    checkOutput("wr_no_outstanding", 64'(outstanding), 64'd0);

    // Read with responder latency 3
    applyStimulus(1'b0, 16'h0082, 64'd0, t);
    @(negedge clk);
    checkOutput("rd_outstanding_1", 64'(outstanding), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    sendResponse(t, 64'h1234, 16'h0082, 2'd0);
    @(negedge clk);
    checkOutput("rd_done_timing", 64'(done_valid), 64'd1);
    checkOutput("rd_outstanding_0", 64'(outstanding), 64'd0);

    // Four back-to-back reads fill the table
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'(16'h0100 + 4 * i), 64'd0, tids[i]);
    @(negedge clk);
    checkOutput("full_ready", 64'(cmd_ready), 64'd0);
    checkOutput("full_outstanding", 64'(outstanding), 64'd4);
    sendResponse(tids[0], 64'hA0, 16'h0100, 2'd0);
    @(negedge clk);
    checkOutput("ready_after_rsp", 64'(cmd_ready), 64'd1);
    checkOutput("outstanding_3", 64'(outstanding), 64'd3);
    sendResponse(tids[2], 64'hA2, 16'h0108, 2'd0);
    sendResponse(tids[3], 64'hA3, 16'h010C, 2'd0);
    sendResponse(tids[1], 64'hA1, 16'h0104, 2'd0);
    @(negedge clk);
    checkOutput("drained_outstanding", 64'(outstanding), 64'd0);

    // Timeout: completion TO+1 cycles after the read strobe cycle
    applyStimulus(1'b0, 16'h0040, 64'd0, t);
    exp_done_q.push_back('{addr: 16'h0040, data: 64'd0, err: 2'd1});
    @(negedge clk);
    repeat (TO) @(negedge clk);
    checkOutput("to_not_early", 64'(done_valid), 64'd0);
    @(negedge clk);
    checkOutput("to_done", 64'(done_valid), 64'd1);
    checkOutput("to_outstanding", 64'(outstanding), 64'd0);

    // Unexpected tid
    sendResponse(9'h1FF, 64'hABCD, 16'h0000, 2'd2);
    @(negedge clk);
    checkOutput("utid_done", 64'(done_valid), 64'd1);

    // Misaligned command
    applyStimulus(1'b0, 16'h0021, 64'd0, t);
    @(negedge clk);
    checkOutput("mis_done", 64'(done_valid), 64'd1);
    checkOutput("mis_no_rd", 64'(mmio_rd_valid), 64'd0);
    checkOutput("mis_no_outstanding", 64'(outstanding), 64'd0);

    // Misaligned losing to a same-cycle response is held and stalls cmd_ready
    applyStimulus(1'b0, 16'h0200, 64'd0, t);
    exp_done_q.push_back('{addr: 16'h0200, data: 64'h55, err: 2'd0});
    rsp_valid = 1'b1;
    rsp_tid   = t;
    rsp_data  = 64'h55;
    applyStimulus(1'b1, 16'h0033, 64'h99, t);
    rsp_valid = 1'b0;
    @(negedge clk);
    checkOutput("coll_rsp_done", 64'(done_valid), 64'd1);
    checkOutput("coll_stall", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    checkOutput("coll_mis_done", 64'(done_valid), 64'd1);
    checkOutput("coll_ready", 64'(cmd_ready), 64'd1);

    // 600 writes wrap the tid counter
    for (int i = 0; i < 600; i++) applyStimulus(1'b1, 16'(2 * i), {32'(i), 32'hCAFE_0000}, t);
    @(negedge clk);

    // Reset with two reads outstanding
    applyStimulus(1'b0, 16'h0300, 64'd0, rt0);
    applyStimulus(1'b0, 16'h0304, 64'd0, rt1);
    @(negedge clk);
    checkOutput("pre_rst_outstanding", 64'(outstanding), 64'd2);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("midrst_ready", 64'(cmd_ready), 64'd0);
    checkOutput("midrst_outstanding", 64'(outstanding), 64'd0);
    checkOutput("midrst_rd_valid", 64'(mmio_rd_valid), 64'd0);
    checkOutput("midrst_tid", 64'(mmio_tid), 64'd0);
    checkOutput("midrst_addr", 64'(mmio_addr), 64'd0);
    exp_tid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("postrst_outstanding", 64'(outstanding), 64'd0);
    sendResponse(rt0, 64'h77, 16'h0000, 2'd2);
    applyStimulus(1'b0, 16'h0400, 64'd0, t);
    @(negedge clk);
    checkOutput("postrst_outstanding_1", 64'(outstanding), 64'd1);
    sendResponse(t, 64'h88, 16'h0400, 2'd0);

    repeat (4) @(negedge clk);
    checkOutput("req_queue_empty", 64'(exp_req_q.size()), 64'd0);
    checkOutput("done_queue_empty", 64'(exp_done_q.size()), 64'd0);
    checkOutput("final_outstanding", 64'(outstanding), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
